// File: rtl/cfg_readback_pkg.sv
// -----------------------------------------------------------------------------
// cfg_readback_pkg
//   Shared definitions for cfg_readback: FSM state encoding, word index map,
//   checksum seed and the elaboration-time table builder pack_cfg_words().
//
//   Word map (each field truncated to the listed LSBs, unlisted bits zero):
//     0 widths   {XLEN[7:0], PLEN[7:0], VLEN[7:0], FLen[7:0]}
//     1 isa      bit 0..23 = RVA .. PerfCounterEn
//     2 icache   {SET_ASSOC[7:0], INDEX_WIDTH[7:0], LINE_WIDTH[15:0]}
//     3 dcache   same layout as word 2
//     4 ports    {Commit[3:0], Issue[3:0], Wb[3:0], Rgpr[3:0], SB[7:0], PMP[7:0]}
//     5 mmu      {ITLB[7:0], DTLB[7:0], STLB depth[7:0], PtLevels[3:0], 4'b0}
//     6 bpred    {RASDepth[7:0], BTBEntries[7:0], BHTEntries[15:0]}
//     7 checksum XOR of words 0..6 XOR seed
// -----------------------------------------------------------------------------
package cfg_readback_pkg;

  localparam int unsigned CFG_NR_WORDS = 8;
  localparam int unsigned CFG_ADDR_W   = 4;
  localparam int unsigned CFG_DATA_W   = 32;

  // Word indices
  localparam int unsigned CFG_W_WIDTHS = 0;
  localparam int unsigned CFG_W_ISA    = 1;
  localparam int unsigned CFG_W_ICACHE = 2;
  localparam int unsigned CFG_W_DCACHE = 3;
  localparam int unsigned CFG_W_PORTS  = 4;
  localparam int unsigned CFG_W_MMU    = 5;
  localparam int unsigned CFG_W_BPRED  = 6;
  localparam int unsigned CFG_W_CSUM   = 7;

  localparam logic [CFG_DATA_W-1:0] CFG_CSUM_SEED = 32'hC0F6_0001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_BURST  = 2'd2
  } cfg_state_e;

  typedef logic [CFG_NR_WORDS-1:0][CFG_DATA_W-1:0] cfg_words_t;

  function automatic cfg_words_t pack_cfg_words(input config_pkg::cva6_cfg_t cfg);
    cfg_words_t w;
    w = '0;

    w[CFG_W_WIDTHS] = {cfg.XLEN[7:0], cfg.PLEN[7:0], cfg.VLEN[7:0], cfg.FLen[7:0]};

    w[CFG_W_ISA] = {8'h00,
                    cfg.PerfCounterEn, cfg.SuperscalarEn, cfg.MmuPresent, cfg.DebugEn,
                    cfg.CvxifEn, cfg.XFVec, cfg.XF8, cfg.XF16ALT,
                    cfg.XF16, cfg.RVZihpm, cfg.RVZicntr, cfg.RVZiCond,
                    cfg.RVZCMP, cfg.RVZCB, cfg.ZKN, cfg.RVV,
                    cfg.RVU, cfg.RVS, cfg.RVH, cfg.RVF,
                    cfg.RVD, cfg.RVC, cfg.RVB, cfg.RVA};

    w[CFG_W_ICACHE] = {cfg.ICACHE_SET_ASSOC[7:0], cfg.ICACHE_INDEX_WIDTH[7:0],
                       cfg.ICACHE_LINE_WIDTH[15:0]};
    w[CFG_W_DCACHE] = {cfg.DCACHE_SET_ASSOC[7:0], cfg.DCACHE_INDEX_WIDTH[7:0],
                       cfg.DCACHE_LINE_WIDTH[15:0]};

    w[CFG_W_PORTS] = {cfg.NrCommitPorts[3:0], cfg.NrIssuePorts[3:0],
                      cfg.NrWbPorts[3:0], cfg.NrRgprPorts[3:0],
                      cfg.NR_SB_ENTRIES[7:0], cfg.NrPMPEntries[7:0]};

    w[CFG_W_MMU] = {cfg.InstrTlbEntries[7:0], cfg.DataTlbEntries[7:0],
                    cfg.SharedTlbDepth[7:0], cfg.PtLevels[3:0], 4'b0000};

    w[CFG_W_BPRED] = {cfg.RASDepth[7:0], cfg.BTBEntries[7:0], cfg.BHTEntries[15:0]};

    // Checksum lets software confirm it read a coherent table.
    w[CFG_W_CSUM] = CFG_CSUM_SEED ^ w[CFG_W_WIDTHS] ^ w[CFG_W_ISA] ^ w[CFG_W_ICACHE]
                  ^ w[CFG_W_DCACHE] ^ w[CFG_W_PORTS] ^ w[CFG_W_MMU] ^ w[CFG_W_BPRED];
    return w;
  endfunction

endpackage

// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
//   Minimal core-configuration type for the configuration readback block.
//   It carries only the fully derived fields that the readback table exposes.
//   Numeric fields are 32-bit unsigned and feature switches are single bits,
//   so a '{default: 0} pattern yields an all-disabled configuration.
// -----------------------------------------------------------------------------
package config_pkg;

  typedef struct packed {
    // Datapath widths
    int unsigned XLEN;
    int unsigned PLEN;
    int unsigned VLEN;
    int unsigned FLen;
    // ISA extensions and feature switches
    bit          RVA;
    bit          RVB;
    bit          RVC;
    bit          RVD;
    bit          RVF;
    bit          RVH;
    bit          RVS;
    bit          RVU;
    bit          RVV;
    bit          ZKN;
    bit          RVZCB;
    bit          RVZCMP;
    bit          RVZiCond;
    bit          RVZicntr;
    bit          RVZihpm;
    bit          XF16;
    bit          XF16ALT;
    bit          XF8;
    bit          XFVec;
    bit          CvxifEn;
    bit          DebugEn;
    bit          MmuPresent;
    bit          SuperscalarEn;
    bit          PerfCounterEn;
    // Instruction cache geometry
    int unsigned ICACHE_SET_ASSOC;
    int unsigned ICACHE_INDEX_WIDTH;
    int unsigned ICACHE_LINE_WIDTH;
    // Data cache geometry
    int unsigned DCACHE_SET_ASSOC;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned DCACHE_LINE_WIDTH;
    // Pipeline ports and buffers
    int unsigned NrCommitPorts;
    int unsigned NrIssuePorts;
    int unsigned NrWbPorts;
    int unsigned NrRgprPorts;
    int unsigned NR_SB_ENTRIES;
    int unsigned NrPMPEntries;
    // MMU
    int unsigned InstrTlbEntries;
    int unsigned DataTlbEntries;
    int unsigned SharedTlbDepth;
    int unsigned PtLevels;
    // Branch prediction
    int unsigned RASDepth;
    int unsigned BTBEntries;
    int unsigned BHTEntries;
  } cva6_cfg_t;

endpackage

// File: rtl/cfg_readback.sv
// -----------------------------------------------------------------------------
// cfg_readback
//   Read-only window onto the elaborated core configuration. A request selects
//   a word index; single mode returns one beat, burst mode streams every word
//   from that index up to the last table entry. The table is a constant built
//   at elaboration, so the block holds only the FSM, an address counter, an
//   abort flag and the registered response.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   req_valid_i  read request valid
//   req_ready_o  high only in IDLE; request taken when valid & ready
//   req_addr_i   word index (indices >= NrWords produce an error beat)
//   req_burst_i  stream words req_addr_i .. NrWords-1
//   abort_i      stop an active burst after the currently presented beat
//   rsp_valid_o  response beat valid
//   rsp_ready_i  consumer accepts the beat
//   rsp_data_o   word data (zero on error beats)
//   rsp_addr_o   index of the presented word
//   rsp_last_o   final beat of the transaction
//   rsp_err_o    index out of range
//   busy_o       FSM not IDLE
// -----------------------------------------------------------------------------
module cfg_readback
  import cfg_readback_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_t'{default: 0},
  parameter int unsigned           NrWords = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [CFG_ADDR_W-1:0] req_addr_i,
  input  logic                  req_burst_i,
  input  logic                  abort_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [CFG_DATA_W-1:0] rsp_data_o,
  output logic [CFG_ADDR_W-1:0] rsp_addr_o,
  output logic                  rsp_last_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  // The word map has exactly CFG_NR_WORDS entries; NrWords must match it.
  localparam cfg_words_t             WORDS        = pack_cfg_words(CVA6Cfg);
  localparam int unsigned            IDX_W        = $clog2(CFG_NR_WORDS);
  localparam logic [CFG_ADDR_W-1:0]  LAST_IDX     = CFG_ADDR_W'(NrWords - 1);
  localparam logic [CFG_ADDR_W:0]    NR_WORDS_EXT = (CFG_ADDR_W + 1)'(NrWords);

  cfg_state_e                  state;
  logic [CFG_ADDR_W-1:0]       cnt;
  logic                        abort_flag;
  logic                        rsp_valid;
  logic [CFG_DATA_W-1:0]       rsp_data;
  logic [CFG_ADDR_W-1:0]       rsp_addr;
  logic                        rsp_last;
  logic                        rsp_err;
  logic                        busy;
  logic                        req_ready;

  logic                        hs;
  logic [CFG_ADDR_W-1:0]       nxt_idx;

  function automatic logic in_range(input logic [CFG_ADDR_W-1:0] idx);
    return {1'b0, idx} < NR_WORDS_EXT;
  endfunction

  // Only called with in-range indices, so the low IDX_W bits select the word.
  function automatic logic [CFG_DATA_W-1:0] word_at(input logic [CFG_ADDR_W-1:0] idx);
    return WORDS[idx[IDX_W-1:0]];
  endfunction

  assign hs      = rsp_valid & rsp_ready_i;
  assign nxt_idx = cnt + CFG_ADDR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      abort_flag <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_last   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            cnt        <= req_addr_i;
            abort_flag <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_addr   <= req_addr_i;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            if (!in_range(req_addr_i)) begin
              // Out-of-range index: one error beat regardless of mode.
              state    <= S_SINGLE;
              rsp_data <= '0;
              rsp_last <= 1'b1;
              rsp_err  <= 1'b1;
            end else begin
              state    <= req_burst_i ? S_BURST : S_SINGLE;
              rsp_data <= word_at(req_addr_i);
              rsp_last <= !req_burst_i || (req_addr_i == LAST_IDX);
              rsp_err  <= 1'b0;
            end
          end
        end

        S_SINGLE: begin
          if (hs) begin
            state      <= S_IDLE;
            abort_flag <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_addr   <= '0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        S_BURST: begin
          if (hs) begin
            // An abort raised earlier, or arriving with this handshake, ends
            // the burst here without ever presenting a last beat.
            if (rsp_last || abort_flag || abort_i) begin
              state      <= S_IDLE;
              abort_flag <= 1'b0;
              rsp_valid  <= 1'b0;
              rsp_data   <= '0;
              rsp_addr   <= '0;
              rsp_last   <= 1'b0;
              rsp_err    <= 1'b0;
              busy       <= 1'b0;
              req_ready  <= 1'b1;
            end else begin
              cnt      <= nxt_idx;
              rsp_addr <= nxt_idx;
              rsp_data <= word_at(nxt_idx);
              rsp_last <= (nxt_idx == LAST_IDX);
            end
          end else if (abort_i) begin
            // The stalled beat stays untouched; remember the abort for later.
            abort_flag <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready;
  assign rsp_valid_o = rsp_valid;
  assign rsp_data_o  = rsp_data;
  assign rsp_addr_o  = rsp_addr;
  assign rsp_last_o  = rsp_last;
  assign rsp_err_o   = rsp_err;
  assign busy_o      = busy;

endmodule

// File: tb/tb_cfg_readback.sv
// -----------------------------------------------------------------------------
// tb_cfg_readback
//   Scoreboard bench for cfg_readback. Expected beats are queued when a
//   request is driven and compared, in order, as the DUT hands beats over.
//   The expected word table is written out by hand from the configuration
//   below; the checksum word is recomputed from that table.
// -----------------------------------------------------------------------------
module tb_cfg_readback;

  localparam config_pkg::cva6_cfg_t TB_CFG = '{
    XLEN: 64, PLEN: 56, VLEN: 64, FLen: 64,
    RVA: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVS: 1'b1, RVU: 1'b1,
    RVZCB: 1'b1, RVZiCond: 1'b1, RVZicntr: 1'b1, RVZihpm: 1'b1,
    CvxifEn: 1'b1, DebugEn: 1'b1, MmuPresent: 1'b1, PerfCounterEn: 1'b1,
    ICACHE_SET_ASSOC: 4, ICACHE_INDEX_WIDTH: 12, ICACHE_LINE_WIDTH: 128,
    DCACHE_SET_ASSOC: 8, DCACHE_INDEX_WIDTH: 12, DCACHE_LINE_WIDTH: 128,
    NrCommitPorts: 2, NrIssuePorts: 1, NrWbPorts: 4, NrRgprPorts: 2,
    NR_SB_ENTRIES: 8, NrPMPEntries: 272,
    InstrTlbEntries: 16, DataTlbEntries: 16, SharedTlbDepth: 64, PtLevels: 3,
    RASDepth: 2, BTBEntries: 32, BHTEntries: 128,
    default: 0
  };

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_addr_i;
  logic        req_burst_i;
  logic        abort_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [3:0]  rsp_addr_o;
  logic        rsp_last_o;
  logic        rsp_err_o;
  logic        busy_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          nbeats   = 0;
  int          first_hs = 0;
  int          last_hs  = 0;
  logic [31:0] exp_w [8];
  beat_t       sbq [$];
  beat_t       held;
  logic        stalled  = 1'b0;

  cfg_readback #(
    .CVA6Cfg (TB_CFG),
    .NrWords (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_burst_i (req_burst_i),
    .abort_i     (abort_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_addr_o  (rsp_addr_o),
    .rsp_last_o  (rsp_last_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled && rsp_valid_o) begin
        check("hold_data", rsp_data_o, held.data);
        check("hold_addr", 32'(rsp_addr_o), 32'(held.addr));
        check("hold_last", 32'(rsp_last_o), 32'(held.last));
        check("hold_err",  32'(rsp_err_o),  32'(held.err));
      end
      if (rsp_valid_o && rsp_ready_i) begin
        check("sb_has_entry", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("beat_addr", 32'(rsp_addr_o), 32'(e.addr));
          check("beat_data", rsp_data_o, e.data);
          check("beat_last", 32'(rsp_last_o), 32'(e.last));
          check("beat_err",  32'(rsp_err_o),  32'(e.err));
        end
        nbeats++;
        if (nbeats == 1) first_hs = cyc;
        last_hs = cyc;
      end
      stalled   = rsp_valid_o && !rsp_ready_i;
      held.addr = rsp_addr_o;
      held.data = rsp_data_o;
      held.last = rsp_last_o;
      held.err  = rsp_err_o;
    end
  end

  task automatic push_beat(input int a, input logic [31:0] d, input logic l, input logic er);
    beat_t b;
    b.addr = 4'(a);
    b.data = d;
    b.last = l;
    b.err  = er;
    sbq.push_back(b);
  endtask

  task automatic push_txn(input int a, input logic burst);
    if (a >= 8) push_beat(a, 32'h0, 1'b1, 1'b1);
    else if (!burst) push_beat(a, exp_w[a], 1'b1, 1'b0);
    else for (int i = a; i < 8; i++) push_beat(i, exp_w[i], i == 7, 1'b0);
  endtask

  // Beats lo..hi of a burst that is cut short, so none is marked last.
  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_beat(i, exp_w[i], 1'b0, 1'b0);
  endtask

  task automatic clear_txn();
    nbeats   = 0;
    first_hs = 0;
    last_hs  = 0;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
  task automatic issue(input int a, input logic burst);
    check("req_ready_idle", 32'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_addr_i  = 4'(a);
    req_burst_i = burst;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("first_beat_latency", 32'(rsp_valid_o), 1);
    check("busy_active", 32'(busy_o), 1);
    check("ready_low_active", 32'(req_ready_o), 0);
  endtask

  task automatic wait_idle(input logic toggle);
    for (int k = 0; k < 100; k++) begin
      if (toggle) rsp_ready_i = (k % 3 == 0);
      @(posedge clk); #1;
      if (!busy_o) break;
    end
    rsp_ready_i = 1'b1;
    check("idle_reached", 32'(busy_o), 0);
    check("sb_drained", 32'(sbq.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] csum;
    exp_w[0] = 32'h4038_4040;
    exp_w[1] = 32'h00B8_74DD;
    exp_w[2] = 32'h040C_0080;
    exp_w[3] = 32'h080C_0080;
    exp_w[4] = 32'h2142_0810;
    exp_w[5] = 32'h1010_4030;
    exp_w[6] = 32'h0220_0080;
    csum = 32'hC0F6_0001;
    for (int i = 0; i < 7; i++) csum = csum ^ exp_w[i];
    exp_w[7] = csum;

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_burst_i = 1'b0;
    abort_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    check("rst_valid", 32'(rsp_valid_o), 0);
    check("rst_data",  rsp_data_o, 0);
    check("rst_addr",  32'(rsp_addr_o), 0);
    check("rst_last",  32'(rsp_last_o), 0);
    check("rst_err",   32'(rsp_err_o), 0);
    check("rst_busy",  32'(busy_o), 0);
    check("rst_ready", 32'(req_ready_o), 1);

    // Single read of word 0
    clear_txn(); push_txn(0, 1'b0); issue(0, 1'b0);
    check("w0_direct", rsp_data_o, 32'h4038_4040);
    check("w0_last", 32'(rsp_last_o), 1);
    check("w0_err", 32'(rsp_err_o), 0);
    wait_idle(1'b0);
    check("idle_data_zero", rsp_data_o, 0);

    // Single read of every other word
    for (int a = 1; a < 8; a++) begin
      clear_txn(); push_txn(a, 1'b0); issue(a, 1'b0); wait_idle(1'b0);
    end

    // Burst from 5 at full rate
    clear_txn(); push_txn(5, 1'b1); issue(5, 1'b1); wait_idle(1'b0);
    check("burst5_beats", 32'(nbeats), 3);
    check("burst5_span", 32'(last_hs - first_hs), 2);

    // Burst from 0 with back-pressure 1,0,0,1,...
    clear_txn(); push_txn(0, 1'b1); issue(0, 1'b1); wait_idle(1'b1);
    check("burst0_beats", 32'(nbeats), 8);

    // Out-of-range index in single and burst mode
    clear_txn(); push_txn(9, 1'b0); issue(9, 1'b0); wait_idle(1'b0);
    check("err_single_beats", 32'(nbeats), 1);
    clear_txn(); push_txn(9, 1'b1); issue(9, 1'b1); wait_idle(1'b0);
    check("err_burst_beats", 32'(nbeats), 1);
    check("err_ready_after", 32'(req_ready_o), 1);

    // Request held through the last handshake is not taken in that cycle
    clear_txn(); push_txn(2, 1'b0); push_txn(2, 1'b0);
    req_valid_i = 1'b1; req_addr_i = 4'd2; req_burst_i = 1'b0;
    @(posedge clk); #1;
    check("b2b_first_valid", 32'(rsp_valid_o), 1);
    @(posedge clk); #1;
    check("b2b_gap_valid", 32'(rsp_valid_o), 0);
    check("b2b_gap_ready", 32'(req_ready_o), 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("b2b_second_valid", 32'(rsp_valid_o), 1);
    wait_idle(1'b0);
    check("b2b_beats", 32'(nbeats), 2);

    // Abort while beat 2 is stalled
    clear_txn(); push_range(0, 2); issue(0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid_o && rsp_addr_o == 4'd2) break;
      @(posedge clk); #1;
    end
    check("abort_at_beat2", 32'(rsp_addr_o), 2);
    rsp_ready_i = 1'b0; abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_still_busy", 32'(busy_o), 1);
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_low", 32'(busy_o), 0);
    check("abort_valid_low", 32'(rsp_valid_o), 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_beats", 32'(nbeats), 3);
    check("abort_sb_empty", 32'(sbq.size()), 0);

    // Abort together with the handshake of a non-last beat
    clear_txn(); push_range(3, 4); issue(3, 1'b1);
    @(posedge clk); #1;
    check("abort_hs_addr", 32'(rsp_addr_o), 4);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_hs_busy", 32'(busy_o), 0);
    check("abort_hs_beats", 32'(nbeats), 2);

    // Abort while idle has no effect on the next burst
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    clear_txn(); push_txn(6, 1'b1); issue(6, 1'b1); wait_idle(1'b0);
    check("idle_abort_beats", 32'(nbeats), 2);

    // Reset during beat 3 of a burst
    clear_txn(); push_txn(0, 1'b1); issue(0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid_o && rsp_addr_o == 4'd3) break;
      @(posedge clk); #1;
    end
    check("rst_mid_beat3", 32'(rsp_addr_o), 3);
    rsp_ready_i = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(rsp_valid_o), 0);
    check("rst_mid_ready", 32'(req_ready_o), 1);
    check("rst_mid_busy", 32'(busy_o), 0);
    check("rst_mid_dropped", 32'(sbq.size()), 5);
    sbq.delete();
    rst_i = 1'b0; rsp_ready_i = 1'b1;
    clear_txn(); push_txn(1, 1'b0); issue(1, 1'b0);
    check("rst_w1_direct", rsp_data_o, exp_w[1]);
    wait_idle(1'b0);
    check("rst_w1_beats", 32'(nbeats), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
